// File: rtl/mod_exp_ctrl_pkg.sv
// Shared types and constants for the modular exponentiation sequencer.
package mod_exp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SQR,
        SQR_WAIT,
        MUL,
        MUL_WAIT,
        FIN
    } state_e;

    localparam int OP_CNT_W = 32;

    // Bit counter must hold the full exponent width, not just width-1.
    function automatic int cnt_width(input int ebits);
        return $clog2(ebits + 1);
    endfunction

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Pulse-start / pulse-done link between the sequencer and the modular multiplier.
interface mod_exp_ctrl_if #(
    parameter int NBITS = 4096
);
    logic             mul_enable_p;
    logic [NBITS-1:0] mul_a;
    logic [NBITS-1:0] mul_b;
    logic [NBITS-1:0] mul_m;
    logic [NBITS-1:0] mul_y;
    logic             mul_done_p;

    modport master (
        output mul_enable_p, mul_a, mul_b, mul_m,
        input  mul_y, mul_done_p
    );

    modport slave (
        input  mul_enable_p, mul_a, mul_b, mul_m,
        output mul_y, mul_done_p
    );
endinterface

// File: rtl/mod_exp_ctrl_bit_seq.sv
// Exponent bit sequencer: MSB-first shift register with remaining-bit counter.
module mod_exp_bit_seq
    import mod_exp_pkg::*;
#(
    parameter int EBITS = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [EBITS-1:0] exp_in,
    output logic             exp_in_zero,
    output logic             bit_msb,
    output logic             cnt_last,
    output logic             cnt_zero
);
    localparam int CW = cnt_width(EBITS);

    logic [EBITS-1:0] exp_q, exp_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        exp_d = exp_q;
        cnt_d = cnt_q;
        if (load) begin
            exp_d = exp_in;
            cnt_d = CW'(EBITS);
        end else if (shift) begin
            exp_d = exp_q << 1;
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            cnt_q <= '0;
        end else begin
            exp_q <= exp_d;
            cnt_q <= cnt_d;
        end
    end

    // The MSB is both the first-one detector during scanning and the next bit afterwards.
    assign exp_in_zero = (exp_in == '0);
    assign bit_msb     = exp_q[EBITS-1];
    assign cnt_last    = (cnt_q == CW'(1));
    assign cnt_zero    = (cnt_q == '0);

endmodule

// File: rtl/mod_exp_ctrl.sv
// Left-to-right binary modular exponentiation sequencer driving an external multiplier.
// Optional multiplier-operation counter enabled by defining MOD_EXP_CTRL_OP_CNT_EN.
module mod_exp_ctrl
    import mod_exp_pkg::*;
#(
    parameter int NBITS = 4096,
    parameter int EBITS = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_p,
    input  logic [NBITS-1:0]    base,
    input  logic [EBITS-1:0]    exp,
    input  logic [NBITS-1:0]    m,
    output logic [NBITS-1:0]    result,
    output logic                busy,
    output logic                done_irq_p,
    output logic [OP_CNT_W-1:0] mul_op_cnt,
    mod_exp_ctrl_if.master      mbus
);
    state_e           state_q, state_d;
    logic [NBITS-1:0] base_q, base_d;
    logic [NBITS-1:0] acc_q, acc_d;
    logic [NBITS-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             en_q, en_d;
    logic [NBITS-1:0] mul_a_q, mul_a_d;
    logic [NBITS-1:0] mul_b_q, mul_b_d;
    logic [NBITS-1:0] mul_m_q, mul_m_d;

    logic seq_load, seq_shift;
    logic exp_in_zero, bit_msb, cnt_last, cnt_zero;

    mod_exp_bit_seq #(
        .EBITS(EBITS)
    ) u_bit_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (seq_load),
        .shift      (seq_shift),
        .exp_in     (exp),
        .exp_in_zero(exp_in_zero),
        .bit_msb    (bit_msb),
        .cnt_last   (cnt_last),
        .cnt_zero   (cnt_zero)
    );

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        acc_d     = acc_q;
        result_d  = result_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        en_d      = 1'b0;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        mul_m_d   = mul_m_q;
        seq_load  = 1'b0;
        seq_shift = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start_p) begin
                    seq_load = 1'b1;
                    base_d   = base;
                    mul_m_d  = m;
                    busy_d   = 1'b1;
                    if (exp_in_zero) begin
                        acc_d   = (m == NBITS'(1)) ? '0 : NBITS'(1);
                        state_d = FIN;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            // Skip leading zeros; the first one seeds the accumulator with the base.
            SCAN: begin
                seq_shift = 1'b1;
                if (bit_msb) begin
                    acc_d   = base_q;
                    state_d = cnt_last ? FIN : SQR;
                end
            end
            SQR: begin
                mul_a_d = acc_q;
                mul_b_d = acc_q;
                en_d    = 1'b1;
                state_d = SQR_WAIT;
            end
            SQR_WAIT: begin
                if (mbus.mul_done_p) begin
                    acc_d     = mbus.mul_y;
                    seq_shift = 1'b1;
                    if (bit_msb) state_d = MUL;
                    else         state_d = cnt_last ? FIN : SQR;
                end
            end
            MUL: begin
                mul_a_d = acc_q;
                mul_b_d = base_q;
                en_d    = 1'b1;
                state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mbus.mul_done_p) begin
                    acc_d   = mbus.mul_y;
                    state_d = cnt_zero ? FIN : SQR;
                end
            end
            FIN: begin
                result_d = acc_q;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            base_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            en_q     <= 1'b0;
            mul_a_q  <= '0;
            mul_b_q  <= '0;
            mul_m_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            en_q     <= en_d;
            mul_a_q  <= mul_a_d;
            mul_b_q  <= mul_b_d;
            mul_m_q  <= mul_m_d;
        end
    end

    assign result            = result_q;
    assign busy              = busy_q;
    assign done_irq_p        = done_q;
    assign mbus.mul_enable_p = en_q;
    assign mbus.mul_a        = mul_a_q;
    assign mbus.mul_b        = mul_b_q;
    assign mbus.mul_m        = mul_m_q;

`ifdef MOD_EXP_CTRL_OP_CNT_EN
    logic [OP_CNT_W-1:0] op_cnt_q, op_cnt_d;

    // Counts in step with the registered enable pulse and saturates rather than wrapping.
    always_comb begin
        op_cnt_d = op_cnt_q;
        if (state_q == IDLE && start_p) begin
            op_cnt_d = '0;
        end else if (en_d && op_cnt_q != '1) begin
            op_cnt_d = op_cnt_q + OP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) op_cnt_q <= '0;
        else        op_cnt_q <= op_cnt_d;
    end

    assign mul_op_cnt = op_cnt_q;
`else
    assign mul_op_cnt = '0;
`endif

endmodule

// File: doc/mod_exp_ctrl.md
Name: mod_exp_ctrl

Overview:
Left-to-right binary modular exponentiation sequencer: computes result = base^exp mod m.
Sits directly upstream of the team's interleaved modular multiplier. Issues square and multiply operations to it over its pulse-start / pulse-done interface and consumes each product.
Owns operand sequencing, exponent bit scanning and completion signalling. Does no arithmetic beyond the exp==0 special case.

Parameters:
NBITS, 4096, width of base, modulus, result and multiplier operands.
EBITS, 4096, width of exponent.

Ports:
clk  input  1  clock.
rst_n  input  1  reset, asynchronous, active-low.
start_p  input  1  one-cycle start pulse; samples base/exp/m.
base  input  NBITS  base; caller guarantees base < m.
exp  input  EBITS  exponent.
m  input  NBITS  modulus; caller guarantees m >= 1.
result  output  NBITS  base^exp mod m; valid from done_irq_p until next start.
busy  output  1  high from cycle after accepted start_p through done_irq_p cycle.
done_irq_p  output  1  one-cycle completion pulse.
mul_enable_p  output  1  one-cycle multiplier start pulse.
mul_a  output  NBITS  multiplier operand a; held stable until mul_done_p.
mul_b  output  NBITS  multiplier operand b; held stable until mul_done_p.
mul_m  output  NBITS  modulus to multiplier; held stable for the whole exponentiation.
mul_y  input  NBITS  multiplier product; sampled only in the mul_done_p cycle.
mul_done_p  input  1  multiplier one-cycle done pulse.
mul_op_cnt  output  32  multiplier-operation count (see Optional Feature).

Behaviour:
- Reset values: result=0, busy=0, done_irq_p=0, mul_enable_p=0, mul_a=0, mul_b=0, mul_m=0, mul_op_cnt=0. FSM resets to IDLE.
- Reset mid-operation aborts immediately. Any in-flight multiplier done pulse is ignored after reset.
- FSM states: IDLE, SCAN, SQR, SQR_WAIT, MUL, MUL_WAIT, FIN.
- IDLE, start_p=1: latch base_r, exp_r, m_r; mul_m<=m.
  - exp==0: go to FIN with acc = (m==1) ? 0 : 1.
  - otherwise: go to SCAN.
- start_p while busy is ignored and does not alter latched operands.
- SCAN: one exponent bit per cycle, shifting exp_r left and decrementing bit counter cnt (initial EBITS).
  - On reaching the first 1 bit: acc<=base_r, consume that bit.
  - cnt==0 after the consume: go to FIN. Otherwise go to SQR.
- SQR: mul_a=acc, mul_b=acc, mul_enable_p=1 for exactly one cycle, then SQR_WAIT.
- SQR_WAIT: on mul_done_p, acc<=mul_y; next exponent bit taken from exp_r MSB, shift exp_r, cnt--.
  - Bit 1: go to MUL.
  - Bit 0: go to SQR if cnt != 0, else FIN.
- MUL: mul_a=acc, mul_b=base_r, pulse mul_enable_p, then MUL_WAIT.
- MUL_WAIT: on mul_done_p, acc<=mul_y; go to SQR if cnt != 0, else FIN.
- FIN: result<=acc, done_irq_p=1 for one cycle, busy drops next cycle, return to IDLE.
- mul_enable_p is never asserted while a multiplier operation is outstanding.
- mul_done_p outside the *_WAIT states is ignored.
- Latency: 2 + SCAN cycles + per-bit multiplier latency. exp==0 completes in 2 cycles with zero multiplier ops.
- base=0, exp>0: result 0 via the normal path.

Optional Feature:
Macro MOD_EXP_CTRL_OP_CNT_EN.
- Defined: mul_op_cnt clears on accepted start_p and increments on each mul_enable_p, saturating at 2^32-1. It holds after done.
- Undefined: mul_op_cnt tied to 0 and no counter logic is inferred.

Decomposition:
- Package mod_exp_pkg: FSM state enum, counter width constant $clog2(EBITS+1), OP_CNT_W=32.
- Sub-module mod_exp_bit_seq is natural: exponent shift register, cnt, first-one detect, next-bit output.
- FSM and operand muxing stay in mod_exp_ctrl.

Test Plan:
Bench pairs the block with the team modular multiplier and a golden pow-mod model; NBITS=EBITS=16 unless noted.
- base=3, exp=5, m=7 -> result=5, exactly one done_irq_p, mul_op_cnt=3 with macro (sqr, sqr, mul).
- base=2, exp=10, m=1000 -> result=24, mul_op_cnt=4.
- exp=0, m=7 -> result=1; exp=0, m=1 -> result=0; both with zero mul_enable_p pulses and done 2 cycles after start.
- base=6, exp=1, m=7 -> result=6, no multiplier ops. A second start_p during a 16-bit exp=0xFFFF run is ignored; result still matches model.
- rst_n asserted mid-MUL_WAIT -> all outputs 0 next cycle. Late mul_done_p ignored. Fresh start then gives correct result.
- 1000 random (base<m, exp, m>=1) at NBITS=EBITS=64 -> all results match model. mul_enable_p never overlaps an outstanding op; mul_m stable throughout.
